mor1kx_rf_bypass_cappuccino: RTL and testbench
==============================================

Name: mor1kx_rf_bypass_cappuccino

Overview:
- Writeback-side operand bypass and register-file write staging for the cappuccino pipeline.
- Consumes the registered writeback result from the RF writeback mux, plus the writeback destination address and write enable.
- Issues a registered, one-cycle RF write pulse.
- Holds the last two committed results so decode/execute operand reads see up-to-date values despite the RF's one-cycle read latency.

Parameters:
- OPTION_OPERAND_WIDTH, 32, data width of results and operands.
- OPTION_RF_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rf_result_i  input  OPTION_OPERAND_WIDTH  writeback result from writeback mux.
- wb_rfd_adr_i  input  OPTION_RF_ADDR_WIDTH  destination register of instruction in WB.
- wb_rf_wb_i  input  1  instruction in WB writes the RF.
- padv_wb_i  input  1  WB stage advances this cycle (commit).
- pipeline_flush_i  input  1  squash instruction currently in WB.
- rfa_adr_i  input  OPTION_RF_ADDR_WIDTH  operand A source register.
- rfb_adr_i  input  OPTION_RF_ADDR_WIDTH  operand B source register.
- rfa_rdat_i  input  OPTION_OPERAND_WIDTH  raw RF read data, port A.
- rfb_rdat_i  input  OPTION_OPERAND_WIDTH  raw RF read data, port B.
- rfa_o  output  OPTION_OPERAND_WIDTH  bypassed operand A.
- rfb_o  output  OPTION_OPERAND_WIDTH  bypassed operand B.
- rf_we_o  output  1  RF write strobe (one-cycle pulse).
- rf_wadr_o  output  OPTION_RF_ADDR_WIDTH  RF write address.
- rf_wdat_o  output  OPTION_OPERAND_WIDTH  RF write data.
- bypass_a_o  output  2  operand A source select: 0 RF, 1 WB, 2 hist0, 3 hist1.
- bypass_b_o  output  2  same for operand B.

Behaviour:
- State: two history entries, hist0 (newest) and hist1. Each entry is {valid, adr, data}.
- Reset (rst low, async):
  - all valids 0; adr and data 0.
  - rf_we_o 0, rf_wadr_o 0, rf_wdat_o 0.
- Capture on rising edge with padv_wb_i=1:
  - hist1 <= hist0.
  - hist0 <= {wb_rf_wb_i & ~pipeline_flush_i, wb_rfd_adr_i, rf_result_i}.
- With padv_wb_i=0, hist0 and hist1 hold.
- pipeline_flush_i only squashes the WB capture. Already-captured history entries are committed and are never cleared except by reset.
- RF write port is registered from the capture:
  - rf_we_o=1 for exactly one cycle after a capture with a valid new hist0.
  - rf_wadr_o/rf_wdat_o = hist0.adr/data.
  - rf_we_o=0 on all other cycles, including stalled cycles.
  - Latency from padv_wb_i edge to RF write strobe: 1 cycle.
- Operand select, combinational, independent per port. Priority, highest first:
  1. WB live: wb_rf_wb_i & ~pipeline_flush_i & adr match -> rf_result_i, select 1.
  2. hist0.valid & adr match -> hist0.data, select 2.
  3. hist1.valid & adr match -> hist1.data, select 3.
  4. Otherwise rf_*_rdat_i, select 0.
- Same-address entries: newest wins by the priority above. Example: hist0 and hist1 both target r5 -> hist0 is used.
- Both ports matching the same entry is legal; both forward the same value.
- Stalled WB (padv_wb_i=0) with wb_rf_wb_i=1: the WB live bypass remains active every cycle until commit.
- No arithmetic; widths pass through unmodified.

Optional Feature:
- Macro: MOR1KX_RF_BYPASS_R0_ZERO_EN.
- Defined:
  - Source address 0 never forwards; the operand is forced to 0 and select reads 0.
  - Captures with destination 0 set valid=0 and raise no rf_we_o.
- Undefined: r0 is treated like any other register (software guarantees r0 writes are zero).

Test Plan:
- Reset: hold rst low with random inputs -> rf_we_o=0, all valids 0. With rfa_adr_i=3 and rfa_rdat_i=0x11, rfa_o=0x11 and bypass_a_o=0.
- Basic write: wb_rf_wb_i=1, wb_rfd_adr_i=4, rf_result_i=0xDEADBEEF, padv_wb_i=1 for one cycle.
  - Same cycle: rfa_adr_i=4 -> rfa_o=0xDEADBEEF, select 1.
  - Next cycle: rf_we_o=1, rf_wadr_o=4, rf_wdat_o=0xDEADBEEF, select 2.
- Priority: commit r7=0x1 then r7=0x2, then present WB r7=0x3 unadvanced -> rfb_o=0x3. Advance WB with wb_rf_wb_i=0 -> rfb_o=0x3 from hist1 (hist0 now invalid), select 3.
- Flush: wb_rf_wb_i=1, adr 9, data 0x55, pipeline_flush_i=1, padv_wb_i=1 -> no bypass that cycle, no rf_we_o next cycle. rfa_adr_i=9 returns rfa_rdat_i.
- Stall: wb_rf_wb_i=1, adr 2, data 0xA5, padv_wb_i=0 for 3 cycles -> rf_we_o stays 0 and rfa_o=0xA5 throughout. On advance, exactly one rf_we_o pulse.
- With MOR1KX_RF_BYPASS_R0_ZERO_EN: commit adr 0, data 0x77 -> no rf_we_o. rfa_adr_i=0 with rfa_rdat_i=0x99 -> rfa_o=0.

Source files
------------

// File: rtl/mor1kx_rf_bypass_cappuccino.sv
// mor1kx_rf_bypass_cappuccino
// Writeback-side operand bypass and register-file write staging for the
// cappuccino pipeline. Keeps the two most recently committed results so that
// operand reads see fresh data despite the RF's one-cycle read latency, and
// issues a registered one-cycle RF write pulse for each valid commit.
//
// Optional feature: define MOR1KX_RF_BYPASS_R0_ZERO_EN to hard-wire r0.
// Source address 0 then always yields 0, and commits to r0 are dropped.
module mor1kx_rf_bypass_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic                            wb_rf_wb_i,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfa_rdat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfb_rdat_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic                            rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wadr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o,
  output logic [1:0]                      bypass_a_o,
  output logic [1:0]                      bypass_b_o
);

  localparam int DW = OPTION_OPERAND_WIDTH;
  localparam int AW = OPTION_RF_ADDR_WIDTH;

  // Operand source encodings
  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_WB    = 2'd1;
  localparam logic [1:0] SEL_HIST0 = 2'd2;
  localparam logic [1:0] SEL_HIST1 = 2'd3;

  // History entries: hist0 is the newest commit, hist1 the one before it
  logic          hist0_valid_q, hist0_valid_d;
  logic [AW-1:0] hist0_adr_q,   hist0_adr_d;
  logic [DW-1:0] hist0_data_q,  hist0_data_d;
  logic          hist1_valid_q, hist1_valid_d;
  logic [AW-1:0] hist1_adr_q,   hist1_adr_d;
  logic [DW-1:0] hist1_data_q,  hist1_data_d;
  logic          rf_we_q,       rf_we_d;

  logic wb_live;
  logic capture_valid;

  // Qualify the WB instruction: live for bypass, and valid for capture
  always_comb begin
    wb_live = wb_rf_wb_i & ~pipeline_flush_i;
`ifdef MOR1KX_RF_BYPASS_R0_ZERO_EN
    capture_valid = wb_live & (wb_rfd_adr_i != '0);
`else
    capture_valid = wb_live;
`endif
  end

  // Shift history on commit and schedule the RF write pulse for the new entry
  always_comb begin
    hist0_valid_d = hist0_valid_q;
    hist0_adr_d   = hist0_adr_q;
    hist0_data_d  = hist0_data_q;
    hist1_valid_d = hist1_valid_q;
    hist1_adr_d   = hist1_adr_q;
    hist1_data_d  = hist1_data_q;
    rf_we_d       = 1'b0;
    if (padv_wb_i) begin
      hist1_valid_d = hist0_valid_q;
      hist1_adr_d   = hist0_adr_q;
      hist1_data_d  = hist0_data_q;
      hist0_valid_d = capture_valid;
      hist0_adr_d   = wb_rfd_adr_i;
      hist0_data_d  = rf_result_i;
      rf_we_d       = capture_valid;
    end
  end

  // History and write-strobe registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist0_valid_q <= 1'b0;
      hist0_adr_q   <= '0;
      hist0_data_q  <= '0;
      hist1_valid_q <= 1'b0;
      hist1_adr_q   <= '0;
      hist1_data_q  <= '0;
      rf_we_q       <= 1'b0;
    end else begin
      hist0_valid_q <= hist0_valid_d;
      hist0_adr_q   <= hist0_adr_d;
      hist0_data_q  <= hist0_data_d;
      hist1_valid_q <= hist1_valid_d;
      hist1_adr_q   <= hist1_adr_d;
      hist1_data_q  <= hist1_data_d;
      rf_we_q       <= rf_we_d;
    end
  end

  // The write port presents the newest history entry; the strobe marks it new
  assign rf_we_o   = rf_we_q;
  assign rf_wadr_o = hist0_adr_q;
  assign rf_wdat_o = hist0_data_q;

  // Operand A source select and mux, newest producer wins
  always_comb begin
    bypass_a_o = SEL_RF;
    rfa_o      = rfa_rdat_i;
    if (wb_live && (rfa_adr_i == wb_rfd_adr_i)) begin
      bypass_a_o = SEL_WB;
      rfa_o      = rf_result_i;
    end else if (hist0_valid_q && (rfa_adr_i == hist0_adr_q)) begin
      bypass_a_o = SEL_HIST0;
      rfa_o      = hist0_data_q;
    end else if (hist1_valid_q && (rfa_adr_i == hist1_adr_q)) begin
      bypass_a_o = SEL_HIST1;
      rfa_o      = hist1_data_q;
    end
`ifdef MOR1KX_RF_BYPASS_R0_ZERO_EN
    if (rfa_adr_i == '0) begin
      bypass_a_o = SEL_RF;
      rfa_o      = '0;
    end
`endif
  end

  // Operand B source select and mux, newest producer wins
  always_comb begin
    bypass_b_o = SEL_RF;
    rfb_o      = rfb_rdat_i;
    if (wb_live && (rfb_adr_i == wb_rfd_adr_i)) begin
      bypass_b_o = SEL_WB;
      rfb_o      = rf_result_i;
    end else if (hist0_valid_q && (rfb_adr_i == hist0_adr_q)) begin
      bypass_b_o = SEL_HIST0;
      rfb_o      = hist0_data_q;
    end else if (hist1_valid_q && (rfb_adr_i == hist1_adr_q)) begin
      bypass_b_o = SEL_HIST1;
      rfb_o      = hist1_data_q;
    end
`ifdef MOR1KX_RF_BYPASS_R0_ZERO_EN
    if (rfb_adr_i == '0) begin
      bypass_b_o = SEL_RF;
      rfb_o      = '0;
    end
`endif
  end

endmodule

// File: tb/tb_mor1kx_rf_bypass_cappuccino.sv
// Directed self-checking bench for mor1kx_rf_bypass_cappuccino.
// Inputs change on the falling edge; checks run 1ns later, so combinational
// outputs reflect the new inputs and registered outputs reflect the last
// rising edge. Covers both builds of MOR1KX_RF_BYPASS_R0_ZERO_EN.
module tb_mor1kx_rf_bypass_cappuccino;

  logic        clk;
  logic        rst;
  logic [31:0] rf_result_i;
  logic [4:0]  wb_rfd_adr_i;
  logic        wb_rf_wb_i;
  logic        padv_wb_i;
  logic        pipeline_flush_i;
  logic [4:0]  rfa_adr_i;
  logic [4:0]  rfb_adr_i;
  logic [31:0] rfa_rdat_i;
  logic [31:0] rfb_rdat_i;
  logic [31:0] rfa_o;
  logic [31:0] rfb_o;
  logic        rf_we_o;
  logic [4:0]  rf_wadr_o;
  logic [31:0] rf_wdat_o;
  logic [1:0]  bypass_a_o;
  logic [1:0]  bypass_b_o;

  int total = 0;
  int bad   = 0;

  mor1kx_rf_bypass_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rf_result_i      (rf_result_i),
    .wb_rfd_adr_i     (wb_rfd_adr_i),
    .wb_rf_wb_i       (wb_rf_wb_i),
    .padv_wb_i        (padv_wb_i),
    .pipeline_flush_i (pipeline_flush_i),
    .rfa_adr_i        (rfa_adr_i),
    .rfb_adr_i        (rfb_adr_i),
    .rfa_rdat_i       (rfa_rdat_i),
    .rfb_rdat_i       (rfb_rdat_i),
    .rfa_o            (rfa_o),
    .rfb_o            (rfb_o),
    .rf_we_o          (rf_we_o),
    .rf_wadr_o        (rf_wadr_o),
    .rf_wdat_o        (rf_wdat_o),
    .bypass_a_o       (bypass_a_o),
    .bypass_b_o       (bypass_b_o)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its hand-computed expectation
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next falling edge, then drive the WB-side inputs
  task automatic apply_stimulus(input logic wb, input logic [4:0] adr, input logic [31:0] dat,
                                input logic padv, input logic flush);
    @(negedge clk);
    wb_rf_wb_i       = wb;
    wb_rfd_adr_i     = adr;
    rf_result_i      = dat;
    padv_wb_i        = padv;
    pipeline_flush_i = flush;
  endtask

  initial begin
    // Reset held low with random inputs; WB kept non-writing for the operand check
    rst              = 1'b0;
    rf_result_i      = $urandom;
    wb_rfd_adr_i     = 5'($urandom);
    wb_rf_wb_i       = 1'b0;
    padv_wb_i        = 1'b1;
    pipeline_flush_i = 1'b0;
    rfa_adr_i        = 5'd3;
    rfb_adr_i        = 5'($urandom);
    rfa_rdat_i       = 32'h11;
    rfb_rdat_i       = 32'h22;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_we",    32'(rf_we_o),    32'd0);
    check_output("reset_wadr",  32'(rf_wadr_o),  32'd0);
    check_output("reset_wdat",  rf_wdat_o,       32'd0);
    check_output("reset_rfa",   rfa_o,           32'h11);
    check_output("reset_sel_a", 32'(bypass_a_o), 32'd0);
    check_output("reset_rfb",   rfb_o,           32'h22);
    check_output("reset_sel_b", 32'(bypass_b_o), 32'd0);

    // Release reset with the pipeline idle
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // Basic write: same-cycle WB bypass, then one write pulse and hist0 bypass
    apply_stimulus(1'b1, 5'd4, 32'hDEADBEEF, 1'b1, 1'b0);
    rfa_adr_i  = 5'd4;
    rfa_rdat_i = 32'h1234;
    #1;
    check_output("basic_live_rfa", rfa_o,           32'hDEADBEEF);
    check_output("basic_live_sel", 32'(bypass_a_o), 32'd1);
    check_output("basic_live_we",  32'(rf_we_o),    32'd0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("basic_we",   32'(rf_we_o),    32'd1);
    check_output("basic_wadr", 32'(rf_wadr_o),  32'd4);
    check_output("basic_wdat", rf_wdat_o,       32'hDEADBEEF);
    check_output("basic_rfa",  rfa_o,           32'hDEADBEEF);
    check_output("basic_sel",  32'(bypass_a_o), 32'd2);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("basic_we_drop", 32'(rf_we_o), 32'd0);

    // Priority: r7=1 then r7=2 committed; newest history entry wins
    rfb_adr_i  = 5'd7;
    rfb_rdat_i = 32'hFFFF;
    apply_stimulus(1'b1, 5'd7, 32'h1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd7, 32'h2, 1'b1, 1'b0);
    #1;
    check_output("prio_we1",   32'(rf_we_o),   32'd1);
    check_output("prio_wdat1", rf_wdat_o,      32'h1);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("prio_newest_rfb", rfb_o,           32'h2);
    check_output("prio_newest_sel", 32'(bypass_b_o), 32'd2);
    check_output("prio_r4_aged_rfa", rfa_o,          32'h1234);
    check_output("prio_r4_aged_sel", 32'(bypass_a_o), 32'd0);
    // WB r7=3 held unadvanced: live WB beats both history entries
    apply_stimulus(1'b1, 5'd7, 32'h3, 1'b0, 1'b0);
    #1;
    check_output("prio_live_rfb", rfb_o,           32'h3);
    check_output("prio_live_sel", 32'(bypass_b_o), 32'd1);
    check_output("prio_stall_we", 32'(rf_we_o),    32'd0);
    apply_stimulus(1'b1, 5'd7, 32'h3, 1'b1, 1'b0);
    // Advance a non-writing instruction: r7=3 moves down to hist1
    apply_stimulus(1'b0, 5'd7, 32'h0, 1'b1, 1'b0);
    #1;
    check_output("prio_h0_rfb",  rfb_o,           32'h3);
    check_output("prio_h0_sel",  32'(bypass_b_o), 32'd2);
    check_output("prio_we3",     32'(rf_we_o),    32'd1);
    check_output("prio_wdat3",   rf_wdat_o,       32'h3);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("prio_h1_rfb",     rfb_o,           32'h3);
    check_output("prio_h1_sel",     32'(bypass_b_o), 32'd3);
    check_output("prio_invalid_we", 32'(rf_we_o),    32'd0);

    // Flush: squashed WB neither bypasses nor writes
    rfa_adr_i  = 5'd9;
    rfa_rdat_i = 32'hAAAA1111;
    apply_stimulus(1'b1, 5'd9, 32'h55, 1'b1, 1'b1);
    #1;
    check_output("flush_live_rfa", rfa_o,           32'hAAAA1111);
    check_output("flush_live_sel", 32'(bypass_a_o), 32'd0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("flush_we",  32'(rf_we_o),    32'd0);
    check_output("flush_rfa", rfa_o,           32'hAAAA1111);
    check_output("flush_sel", 32'(bypass_a_o), 32'd0);
    check_output("flush_r7_gone_rfb", rfb_o,   32'hFFFF);

    // Stall: live bypass persists for three stalled cycles, no write
    rfa_adr_i  = 5'd2;
    rfa_rdat_i = 32'h5;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'd2, 32'hA5, 1'b0, 1'b0);
      #1;
      check_output($sformatf("stall%0d_rfa", i), rfa_o,           32'hA5);
      check_output($sformatf("stall%0d_sel", i), 32'(bypass_a_o), 32'd1);
      check_output($sformatf("stall%0d_we", i),  32'(rf_we_o),    32'd0);
    end
    apply_stimulus(1'b1, 5'd2, 32'hA5, 1'b1, 1'b0);
    #1;
    check_output("stall_adv_rfa", rfa_o, 32'hA5);
    // Both ports reading r2 forward the same hist0 entry
    rfb_adr_i = 5'd2;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("stall_pulse_we",   32'(rf_we_o),    32'd1);
    check_output("stall_pulse_wadr", 32'(rf_wadr_o),  32'd2);
    check_output("stall_pulse_wdat", rf_wdat_o,       32'hA5);
    check_output("stall_both_a_sel", 32'(bypass_a_o), 32'd2);
    check_output("stall_both_b",     rfb_o,           32'hA5);
    check_output("stall_both_b_sel", 32'(bypass_b_o), 32'd2);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("stall_single_pulse", 32'(rf_we_o), 32'd0);

    // r0 handling: commit r0=0x77 and read r0 with raw data 0x99
    rfa_adr_i  = 5'd0;
    rfa_rdat_i = 32'h99;
    apply_stimulus(1'b1, 5'd0, 32'h77, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef MOR1KX_RF_BYPASS_R0_ZERO_EN
    check_output("r0_we",  32'(rf_we_o),    32'd0);
    check_output("r0_rfa", rfa_o,           32'h0);
    check_output("r0_sel", 32'(bypass_a_o), 32'd0);
`else
    check_output("r0_we",  32'(rf_we_o),    32'd1);
    check_output("r0_rfa", rfa_o,           32'h77);
    check_output("r0_sel", 32'(bypass_a_o), 32'd2);
`endif

    // Asynchronous reset mid-cycle clears the pending write and history
    rfa_adr_i = 5'd2;
    rfb_adr_i = 5'd2;
    apply_stimulus(1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("pre_async_we", 32'(rf_we_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_we",    32'(rf_we_o),    32'd0);
    check_output("async_wadr",  32'(rf_wadr_o),  32'd0);
    check_output("async_wdat",  rf_wdat_o,       32'd0);
    check_output("async_rfa",   rfa_o,           32'h99);
    check_output("async_sel_a", 32'(bypass_a_o), 32'd0);
    check_output("async_sel_b", 32'(bypass_b_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
